// File: rtl/csi_pkt_pkg.sv
// rtl/csi_pkt_pkg.sv - CSI-2 packet builder types, data-type codes, ECC and CRC helpers
package csi_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE, H_DI, H_D0, H_D1, H_ECC, PAYLOAD, CRC_LO, CRC_HI
  } state_t;

  localparam logic [5:0] DT_FS   = 6'h00;
  localparam logic [5:0] DT_FE   = 6'h01;
  localparam logic [5:0] DT_LS   = 6'h02;
  localparam logic [5:0] DT_LE   = 6'h03;
  localparam logic [5:0] DT_RAW8 = 6'h2A;

  // Header Hamming parity; each mask selects the data bits covered by one parity bit.
  function automatic logic [5:0] csi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  // Reflected CCITT step, data consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/csi_crc16.sv
// rtl/csi_crc16.sv - byte-wise CRC-16 accumulator, seeded on clear
module csi_crc16
  import csi_pkt_pkg::*;
(
  input  logic        hs_clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;

  always_ff @(posedge hs_clk or posedge rst) begin
    if (rst) begin
      crc_q <= '0;
    end else if (clr_i) begin
      crc_q <= 16'hFFFF;
    end else if (en_i) begin
      crc_q <= crc16_byte(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/csi_packet_builder.sv
// rtl/csi_packet_builder.sv - serialises CSI-2 short/long packets into a byte stream
module csi_packet_builder
  import csi_pkt_pkg::*;
#(
  parameter int WC_W = 16,
  parameter int VC_W = 2,
  parameter int DT_W = 6
) (
  input  logic            hs_clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_long,
  input  logic [VC_W-1:0] cmd_vc,
  input  logic [DT_W-1:0] cmd_dt,
  input  logic [WC_W-1:0] cmd_wc,
  input  logic            pix_valid,
  output logic            pix_ready,
  input  logic [7:0]      pix_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic            out_sop,
  output logic            out_eop,
  output logic            busy
);

  state_t          state_q, state_d;
  logic [7:0]      di_q, di_d;
  logic [WC_W-1:0] wc_q, wc_d;
  logic [WC_W-1:0] rem_q, rem_d;
  logic            long_q, long_d;
  logic            ov_q, ov_d;
  logic [7:0]      od_q, od_d;
  logic            sop_q, sop_d;
  logic            eop_q, eop_d;
  logic            load, cmd_acc, pix_acc;
  logic [15:0]     crc;

  assign load      = !ov_q || out_ready;
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign pix_ready = (state_q == PAYLOAD) && load;
  assign pix_acc   = pix_valid && pix_ready;

  csi_crc16 u_crc (
    .hs_clk (hs_clk),
    .rst    (rst),
    .clr_i  (cmd_acc),
    .en_i   (pix_acc),
    .data_i (pix_data),
    .crc_o  (crc)
  );

  always_comb begin
    state_d = state_q;
    di_d    = di_q;
    wc_d    = wc_q;
    rem_d   = rem_q;
    long_d  = long_q;
    ov_d    = ov_q;
    od_d    = od_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    // The output register empties on a load unless a state below refills it.
    if (load) begin
      ov_d  = 1'b0;
      sop_d = 1'b0;
      eop_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          di_d    = {cmd_vc, cmd_dt};
          wc_d    = cmd_wc;
          long_d  = cmd_long;
          state_d = H_DI;
        end
      end
      H_DI: begin
        if (load) begin
          ov_d    = 1'b1;
          od_d    = di_q;
          sop_d   = 1'b1;
          state_d = H_D0;
        end
      end
      H_D0: begin
        if (load) begin
          ov_d    = 1'b1;
          od_d    = wc_q[7:0];
          state_d = H_D1;
        end
      end
      H_D1: begin
        if (load) begin
          ov_d    = 1'b1;
          od_d    = wc_q[15:8];
          state_d = H_ECC;
        end
      end
      H_ECC: begin
        if (load) begin
          ov_d  = 1'b1;
          od_d  = {2'b00, csi_ecc({wc_q, di_q})};
          eop_d = !long_q;
          rem_d = wc_q;
          if (!long_q) begin
            state_d = IDLE;
          end else if (wc_q == '0) begin
            state_d = CRC_LO;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (pix_acc) begin
          ov_d  = 1'b1;
          od_d  = pix_data;
          rem_d = rem_q - 1'b1;
          if (rem_q == WC_W'(1)) begin
            state_d = CRC_LO;
          end
        end
      end
      CRC_LO: begin
        if (load) begin
          ov_d    = 1'b1;
          od_d    = crc[7:0];
          state_d = CRC_HI;
        end
      end
      CRC_HI: begin
        if (load) begin
          ov_d    = 1'b1;
          od_d    = crc[15:8];
          eop_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hs_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      di_q    <= '0;
      wc_q    <= '0;
      rem_q   <= '0;
      long_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      di_q    <= di_d;
      wc_q    <= wc_d;
      rem_q   <= rem_d;
      long_q  <= long_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign busy      = (state_q != IDLE) || ov_q;

endmodule
